halfband_sample_packer: RTL and testbench

HALFBAND_SAMPLE_PACKER -- requirements
Module: halfband_sample_packer

---
 rtl/halfband_pkg.sv | 24 ++
 rtl/sample_fifo.sv | 68 ++++++
 rtl/halfband_sample_packer.sv | 138 +++++++++++++
 tb/tb_halfband_sample_packer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/halfband_pkg.sv
// Shared constants and types for the halfband sample packer.
//   SAMPLE_WIDTH_DEFAULT : default width of one decimated sample
//   WORD_WIDTH           : packed word width (two samples)
//   DROP_COUNT_WIDTH     : width of the saturating dropped-word counter
//   pair_state_t         : pairing register state (empty / holding low half)
//   sat_inc              : saturating increment for the drop counter
package halfband_pkg;

    localparam int unsigned SAMPLE_WIDTH_DEFAULT = 16;
    localparam int unsigned WORD_WIDTH           = 2 * SAMPLE_WIDTH_DEFAULT;
    localparam int unsigned DROP_COUNT_WIDTH     = 8;

    typedef enum logic {
        PAIR_EMPTY = 1'b0,
        PAIR_HALF  = 1'b1
    } pair_state_t;

    function automatic logic [DROP_COUNT_WIDTH-1:0] sat_inc(
        input logic [DROP_COUNT_WIDTH-1:0] v
    );
        return (v == '1) ? v : v + DROP_COUNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Packed-word FIFO for the halfband sample packer.
//   clk, reset : clock, asynchronous active-high reset
//   push       : write request; written if not full, or if a pop happens this cycle
//   push_data  : word to write
//   pop        : read request; ignored while empty
//   pop_data   : head word (zero while empty)
//   full/empty : occupancy flags
//   count      : words held, 0..DEPTH
module sample_fifo #(
    parameter int unsigned DATA_WIDTH = 33,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [DATA_WIDTH-1:0]      push_data,
    input  logic                       pop,
    output logic [DATA_WIDTH-1:0]      pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_count;
    logic                  w_do_pop;
    logic                  w_do_push;

    assign empty     = (r_count == '0);
    assign full      = (r_count == (AW+1)'(DEPTH));
    assign count     = r_count;
    assign w_do_pop  = pop && !empty;
    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign w_do_push = push && (!full || w_do_pop);
    assign pop_data  = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/halfband_sample_packer.sv
// Packs pairs of decimated halfband samples into double-width words and
// queues them for a ready/valid consumer.
//   clk, reset      : clock, asynchronous active-high reset
//   valid_in/data_in: one-cycle sample strobe and sample (no backpressure)
//   flush           : emit a pending half word as a zero-padded partial word
//   m_valid/m_ready : output handshake
//   m_data          : {later sample, earlier sample} of the head word
//   m_partial       : head word's upper half is flush padding
//   overflow        : sticky, a completed word was dropped on a full FIFO
//   overflow_clear  : clears overflow and drop_count (a same-cycle drop wins)
//   drop_count      : saturating count of dropped words
//   fill_level      : words held in the FIFO
module halfband_sample_packer
    import halfband_pkg::*;
#(
    parameter int unsigned SAMPLE_WIDTH = SAMPLE_WIDTH_DEFAULT,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          valid_in,
    input  logic [SAMPLE_WIDTH-1:0]       data_in,
    input  logic                          flush,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [2*SAMPLE_WIDTH-1:0]     m_data,
    output logic                          m_partial,
    output logic                          overflow,
    input  logic                          overflow_clear,
    output logic [DROP_COUNT_WIDTH-1:0]   drop_count,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level
);

    localparam int unsigned W2 = 2 * SAMPLE_WIDTH;

    pair_state_t             r_state;
    pair_state_t             w_next_state;
    logic [SAMPLE_WIDTH-1:0] r_held;
    logic                    r_overflow;
    logic [DROP_COUNT_WIDTH-1:0] r_drop_count;

    logic                    w_push;
    logic [W2-1:0]           w_word;
    logic                    w_word_partial;
    logic                    w_pop;
    logic                    w_drop;
    logic [W2:0]             w_head;
    logic                    w_full;
    logic                    w_empty;

    // State register and held low-half sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= PAIR_EMPTY;
            r_held  <= '0;
        end else begin
            r_state <= w_next_state;
            if (valid_in && r_state == PAIR_EMPTY) begin
                r_held <= data_in;
            end
        end
    end

    // Next state: the sample is paired first, then flush acts on the result,
    // so any accepted sample or flush of a held sample leaves us empty except
    // a lone first sample without flush.
    always_comb begin
        w_next_state = r_state;
        if (valid_in) begin
            if (r_state == PAIR_EMPTY && !flush) begin
                w_next_state = PAIR_HALF;
            end else begin
                w_next_state = PAIR_EMPTY;
            end
        end else if (flush) begin
            w_next_state = PAIR_EMPTY;
        end
    end

    // Push decode: at most one word per cycle.
    always_comb begin
        w_push         = 1'b0;
        w_word         = '0;
        w_word_partial = 1'b0;
        if (valid_in) begin
            if (r_state == PAIR_HALF) begin
                w_push = 1'b1;
                w_word = {data_in, r_held};
            end else if (flush) begin
                w_push         = 1'b1;
                w_word         = {{SAMPLE_WIDTH{1'b0}}, data_in};
                w_word_partial = 1'b1;
            end
        end else if (flush && r_state == PAIR_HALF) begin
            w_push         = 1'b1;
            w_word         = {{SAMPLE_WIDTH{1'b0}}, r_held};
            w_word_partial = 1'b1;
        end
    end

    assign w_pop  = m_ready && !w_empty;
    assign w_drop = w_push && w_full && !w_pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (w_drop) begin
            r_overflow   <= 1'b1;
            r_drop_count <= overflow_clear ? DROP_COUNT_WIDTH'(1) : sat_inc(r_drop_count);
        end else if (overflow_clear) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end
    end

    sample_fifo #(
        .DATA_WIDTH (W2 + 1),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data ({w_word_partial, w_word}),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (fill_level)
    );

    assign m_valid    = !w_empty;
    assign m_data     = w_head[W2-1:0];
    assign m_partial  = w_head[W2];
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_halfband_sample_packer.sv
module tb_halfband_sample_packer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_in = 1'b0;
    logic [15:0] data_in = '0;
    logic        flush = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
    logic        m_partial;
    logic        overflow;
    logic        overflow_clear = 1'b0;
    logic [7:0]  drop_count;
    logic [3:0]  fill_level;

    int unsigned checks = 0;
    int unsigned failures = 0;

    always #5 clk = ~clk;

    halfband_sample_packer #(
        .SAMPLE_WIDTH (16),
        .FIFO_DEPTH   (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .valid_in       (valid_in),
        .data_in        (data_in),
        .flush          (flush),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_partial      (m_partial),
        .overflow       (overflow),
        .overflow_clear (overflow_clear),
        .drop_count     (drop_count),
        .fill_level     (fill_level)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs and checks happen 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] s);
        valid_in = 1'b1;
        data_in  = s;
        tick();
        valid_in = 1'b0;
    endtask

    initial begin
        logic [15:0] lo;
        logic [15:0] hi;

        // Reset state
        tick();
        tick();
        check_eq("rst_valid",   m_valid, 0);
        check_eq("rst_data",    m_data, 0);
        check_eq("rst_partial", m_partial, 0);
        check_eq("rst_ovf",     overflow, 0);
        check_eq("rst_drop",    drop_count, 0);
        check_eq("rst_fill",    fill_level, 0);
        reset = 1'b0;
        tick();

        // Basic pairing with a ready consumer
        m_ready = 1'b1;
        send(16'h0001);
        check_eq("pair_no_word", m_valid, 0);
        send(16'h0002);
        check_eq("pair1_valid", m_valid, 1);
        check_eq("pair1_data",  m_data, 32'h0002_0001);
        check_eq("pair1_part",  m_partial, 0);
        send(16'h0003);
        check_eq("pair1_popped", m_valid, 0);
        send(16'h0004);
        check_eq("pair2_data", m_data, 32'h0004_0003);
        check_eq("pair2_part", m_partial, 0);
        tick();
        check_eq("pair_drained", fill_level, 0);
        m_ready = 1'b0;

        // Flush of a pending half word, then a no-op flush
        send(16'h8001);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("flush_fill", fill_level, 1);
        check_eq("flush_data", m_data, 32'h0000_8001);
        check_eq("flush_part", m_partial, 1);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("flush_noop", fill_level, 0);

        // Sample and flush together: first sample -> partial; completing sample -> full word only
        valid_in = 1'b1; data_in = 16'h00AB; flush = 1'b1;
        tick();
        valid_in = 1'b0; flush = 1'b0;
        check_eq("vf_first_fill", fill_level, 1);
        check_eq("vf_first_data", m_data, 32'h0000_00AB);
        check_eq("vf_first_part", m_partial, 1);
        send(16'h0011);
        valid_in = 1'b1; data_in = 16'h0022; flush = 1'b1;
        tick();
        valid_in = 1'b0; flush = 1'b0;
        check_eq("vf_second_fill", fill_level, 2);
        m_ready = 1'b1;
        tick();
        check_eq("vf_second_data", m_data, 32'h0022_0011);
        check_eq("vf_second_part", m_partial, 0);
        tick();
        check_eq("vf_drained", fill_level, 0);

        // Stall: 18 samples fill 8 words and drop the ninth
        m_ready = 1'b0;
        for (int i = 0; i < 18; i++) send(16'(i));
        check_eq("ovf_fill",  fill_level, 8);
        check_eq("ovf_flag",  overflow, 1);
        check_eq("ovf_count", drop_count, 1);
        tick();
        check_eq("stall_hold", m_data, 32'h0001_0000);
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            lo = 16'(2 * i);
            hi = 16'(2 * i + 1);
            check_eq($sformatf("drain_%0d", i), m_data, {hi, lo});
            tick();
        end
        check_eq("drain_empty", m_valid, 0);
        m_ready = 1'b0;
        overflow_clear = 1'b1;
        tick();
        overflow_clear = 1'b0;
        check_eq("clr_flag",  overflow, 0);
        check_eq("clr_count", drop_count, 0);

        // Full FIFO with a pop in the completing cycle
        for (int i = 0; i < 16; i++) send(16'(i));
        send(16'h0100);
        m_ready = 1'b1;
        send(16'h0101);
        check_eq("fullpop_fill", fill_level, 8);
        check_eq("fullpop_ovf",  overflow, 0);
        check_eq("fullpop_head", m_data, 32'h0003_0002);
        for (int i = 0; i < 7; i++) tick();
        check_eq("fullpop_last", m_data, 32'h0101_0100);
        tick();
        check_eq("fullpop_empty", fill_level, 0);
        m_ready = 1'b0;

        // Clear coincident with a drop, then clear alone, then saturation
        for (int i = 0; i < 18; i++) send(16'(i));
        check_eq("drop1_count", drop_count, 1);
        send(16'h0050);
        overflow_clear = 1'b1;
        send(16'h0051);
        overflow_clear = 1'b0;
        check_eq("clrdrop_flag",  overflow, 1);
        check_eq("clrdrop_count", drop_count, 1);
        overflow_clear = 1'b1;
        tick();
        overflow_clear = 1'b0;
        check_eq("clralone_flag",  overflow, 0);
        check_eq("clralone_count", drop_count, 0);
        for (int i = 0; i < 600; i++) send(16'(i));
        check_eq("sat_count", drop_count, 255);
        overflow_clear = 1'b1;
        m_ready = 1'b1;
        tick();
        overflow_clear = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check_eq("sat_drained", fill_level, 0);
        m_ready = 1'b0;

        // Reset mid-operation discards words and the pending half
        for (int i = 1; i <= 6; i++) send(16'(i));
        send(16'h1234);
        check_eq("pre_rst_fill", fill_level, 3);
        reset = 1'b1;
        #2;
        check_eq("midrst_valid", m_valid, 0);
        check_eq("midrst_data",  m_data, 0);
        check_eq("midrst_fill",  fill_level, 0);
        check_eq("midrst_part",  m_partial, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        send(16'hAAAA);
        send(16'h5555);
        check_eq("postrst_data", m_data, 32'h5555_AAAA);
        check_eq("postrst_part", m_partial, 0);
        check_eq("postrst_fill", fill_level, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
